// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and FSM state type for the sequential multiply/divide unit
package muldiv_pkg;

    localparam int         WIDTH  = 16;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam int         CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide step
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH:0]   w_add;
    logic             w_q;

    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, i_b};
        w_shift = {i_hi, i_lo[WIDTH-1]};
        // the partial remainder is below 2*divisor, so the difference always fits in WIDTH bits
        w_diff  = w_shift[WIDTH-1:0] - i_b;
        w_q     = (w_shift >= {1'b0, i_b});
        w_add   = i_lo[0] ? w_sum : {1'b0, i_hi};
        if (i_is_div) begin
            o_hi = w_q ? w_diff : w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_q};
        end else begin
            o_hi = w_add[WIDTH:1];
            o_lo = {w_add[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - fixed-latency iterative unsigned multiply/divide with pipeline stall handshake
module muldiv_seq #(
    parameter int         WIDTH  = muldiv_pkg::WIDTH,
    parameter logic [3:0] OP_MUL = muldiv_pkg::OP_MUL,
    parameter logic [3:0] OP_DIV = muldiv_pkg::OP_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div0
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_lo;
    logic [WIDTH-1:0] r_res_hi;
    logic             r_div0;
    logic             w_accept;
    logic             w_is_div_req;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    assign w_is_div_req = (func == OP_DIV);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        stall    = 1'b0;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                // flush outranks a same-cycle start
                w_accept = start && !flush && ((func == OP_MUL) || w_is_div_req);
                stall    = w_accept;
                if (w_accept) w_next = RUN;
            end
            RUN: begin
                stall = 1'b1;
                if (flush)                   w_next = IDLE;
                else if (r_cnt == LAST_ITER) w_next = DONE;
            end
            DONE: begin
                done   = !flush;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            r_div0   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                // multiply: multiplier shifts through lo, multiplicand held in r_b
                r_is_div <= w_is_div_req;
                r_cnt    <= '0;
                r_hi     <= '0;
                r_lo     <= w_is_div_req ? op_a : op_b;
                r_b      <= w_is_div_req ? op_b : op_a;
            end else if (r_state == RUN && !flush) begin
                r_hi  <= w_hi;
                r_lo  <= w_lo;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST_ITER) begin
                    r_res_hi <= w_hi;
                    r_res_lo <= w_lo;
                    r_div0   <= r_is_div && (r_b == '0);
                end
            end
        end
    end

    assign res_lo = r_res_lo;
    assign res_hi = r_res_hi;
    assign div0   = r_div0;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq: vector table, random model, flush/reset corners
module tb_muldiv_seq;

    localparam logic [3:0] F_MUL = 4'b0001;
    localparam logic [3:0] F_DIV = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  func = 4'b0000;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done, div0;
    logic [15:0] res_lo, res_hi;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] last_lo = '0;
    logic [15:0] last_hi = '0;
    logic        last_d0 = 1'b0;

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        d0;
    } vec_t;

    vec_t vecs[9];

    muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func   (func),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .res_lo (res_lo),
        .res_hi (res_hi),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] lo, output logic [15:0] hi, output logic d0);
        logic [31:0] p;
        if (f == F_MUL) begin
            p  = 32'(a) * 32'(b);
            lo = p[15:0];
            hi = p[31:16];
            d0 = 1'b0;
        end else if (b == 16'd0) begin
            lo = 16'hFFFF;
            hi = a;
            d0 = 1'b1;
        end else begin
            lo = a / b;
            hi = a % b;
            d0 = 1'b0;
        end
    endfunction

    // Presents one request, optionally pokes a stray start mid-run, and checks timing and results.
    task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] elo, input logic [15:0] ehi, input logic ed0, input int poke_k);
        int lat;
        int stalls;
        int dones;
        lat = -1; stalls = 0; dones = 0;
        @(negedge clk);
        func = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        if (stall) stalls++;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = (k == poke_k);
            if (k == poke_k) begin
                func = F_MUL; op_a = 16'hDEAD; op_b = 16'hBEEF;
            end
            #1;
            if (stall) stalls++;
            if (done) begin
                dones++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd17);
        chk({tag, " stall cycles"}, 32'(stalls), 32'd17);
        chk({tag, " done pulses"}, 32'(dones), 32'd1);
        chk({tag, " res_lo"}, 32'(res_lo), 32'(elo));
        chk({tag, " res_hi"}, 32'(res_hi), 32'(ehi));
        chk({tag, " div0"}, 32'(div0), 32'(ed0));
        last_lo = elo; last_hi = ehi; last_d0 = ed0;
    endtask

    initial begin
        logic [3:0]  rf;
        logic [15:0] ra, rb, mlo, mhi;
        logic        md0;
        int          dcount;

        vecs[0] = '{F_MUL, 16'd3,    16'd5,    16'h000F, 16'h0000, 1'b0};
        vecs[1] = '{F_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
        vecs[2] = '{F_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0};
        vecs[3] = '{F_DIV, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
        vecs[4] = '{F_MUL, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{F_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        vecs[6] = '{F_DIV, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0};
        vecs[7] = '{F_MUL, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0};
        vecs[8] = '{F_DIV, 16'd7,    16'd7,    16'd1,    16'd0,    1'b0};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset res_lo", 32'(res_lo), 32'd0);
        chk("reset res_hi", 32'(res_hi), 32'd0);
        chk("reset div0", 32'(div0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].d0, 0);

        // unsupported function code is ignored
        @(negedge clk);
        func = 4'b0100; op_a = 16'd9; op_b = 16'd9; start = 1'b1;
        #1;
        chk("badfunc stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("badfunc busy", 32'(busy), 32'd0);

        // stray start while busy must not disturb the operation
        run_op("busy-start", F_DIV, 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 5);

        // flush and start together: flush wins
        @(negedge clk);
        func = F_MUL; op_a = 16'd2; op_b = 16'd2; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush+start stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush+start busy", 32'(busy), 32'd0);

        // flush at iteration 5
        @(negedge clk);
        func = F_MUL; op_a = 16'd77; op_b = 16'd88; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush stall", 32'(stall), 32'd0);
        chk("flush res_lo kept", 32'(res_lo), 32'(last_lo));
        chk("flush res_hi kept", 32'(res_hi), 32'(last_hi));
        chk("flush div0 kept", 32'(div0), 32'(last_d0));
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("flush no done", 32'(dcount), 32'd0);
        run_op("after-flush", F_MUL, 16'd300, 16'd300, 16'h5F90, 16'h0001, 1'b0, 0);

        // reset pulse at iteration 8
        @(negedge clk);
        func = F_DIV; op_a = 16'd500; op_b = 16'd3; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst res_lo", 32'(res_lo), 32'd0);
        chk("rst res_hi", 32'(res_hi), 32'd0);
        chk("rst div0", 32'(div0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst no done", 32'(dcount), 32'd0);

        // randomized operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? F_MUL : F_DIV;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
            model(rf, ra, rb, mlo, mhi, md0);
            run_op($sformatf("rand%0d", i), rf, ra, rb, mlo, mhi, md0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
